slp_param_loader: RTL
=====================

Name: slp_param_loader

Overview:
- Upstream feeder for the 3-layer perceptron engine.
- Accepts a serial stream of 32-bit words over a valid/ready handshake and assembles them into shadow registers. Word order: input vector, input-hidden weights, hidden-hidden weights, hidden-output weights.
- Commits the shadow set to stable flat parallel buses (ip/ib/hb/ob) only at the engine's frame boundary, so the engine never samples a half-loaded set.
- Double-buffered: the next frame streams in while the current one is being processed.

Parameters:
- ID, 10, input vector length (words)
- HID, 3, first hidden layer width
- HOD, 5, second hidden layer width
- OD, 1, output width
- CNT_W, 16, frame counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_data  in  32  stream word
- s_valid  in  1  word valid
- s_ready  out  1  loader can accept a word
- s_last  in  1  marks the final word of a frame
- cfg_ip_only  in  1  frame carries the input vector only (see Optional Feature)
- slp_state  in  8  engine state counter
- slp_level  in  2  engine layer index
- act_ip  out  ID*32  committed input vector
- act_ib  out  ID*HID*32  committed input-hidden weights
- act_hb  out  HID*HOD*32  committed hidden-hidden weights
- act_ob  out  HOD*OD*32  committed hidden-output weights
- act_valid  out  1  at least one frame committed since reset
- fill_seg  out  2  segment being filled: 0=ip, 1=ib, 2=hb, 3=ob
- err_len  out  1  sticky frame-length error
- frame_cnt  out  CNT_W  committed frame count, wraps modulo 2^CNT_W

Behaviour:
- Reset values: all act_* = 0, shadow = 0, act_valid=0, s_ready=0, fill_seg=0, err_len=0, frame_cnt=0, state=FILL, idx=0.
- Reset mid-stream or mid-pending discards the partial frame; nothing is committed.
- Flat-bus ordering: element k of a segment occupies bits [(N-k)*32-1 : (N-k-1)*32], where N is the segment word count. The first word of a segment lands in the MSB word. Weight element (i,j) is k = i*cols + j.
- TOTAL = ID + ID*HID + HID*HOD + HOD*OD (60 at defaults).
- The global index idx runs 0..TOTAL-1. Segment and offset are derived from cumulative boundaries: ip [0,ID), ib [ID, ID+ID*HID), and so on.
- States:
  - FILL: s_ready=1. A transfer occurs when s_valid&&s_ready; the word is written to the shadow slot for idx.
  - PEND: s_ready=0. Waits for the commit point.
- Transitions from FILL, on a transfer:
  - idx==TOTAL-1 && s_last: go to PEND; idx←0.
  - s_last && idx<TOTAL-1, or idx==TOTAL-1 && !s_last: set err_len; discard the frame; idx←0; stay in FILL. The shadow is not committed; stale shadow words are simply overwritten by the next frame.
  - otherwise: idx+1.
- Commit point: slp_level==2 && slp_state==(HOD+2)*OD+2. This is the engine's last cycle before it returns to state 0 and samples its inputs.
- PEND && commit point, on the clock edge:
  - act_* ← shadow, act_valid←1, frame_cnt+1.
  - Next state FILL.
  - act_* are stable at the engine's following sampling edge.
- If the commit point occurs in the same cycle the last word is accepted, it is missed; the commit happens at the next frame boundary.
- act_* change only on commit. They hold value otherwise, including while err_len is set.
- err_len clears only on rst.
- fill_seg reflects the segment of the current idx in FILL; it reads 0 in PEND.

Optional Feature:
- Macro: SLP_LOADER_WEIGHT_SKIP_EN.
- With the macro:
  - cfg_ip_only is sampled on the first transfer of a frame (idx==0) and held for that frame.
  - If set, the frame is ID words long, so the length check uses ID-1 as the last index.
  - The commit updates act_ip only; act_ib/hb/ob are retained. frame_cnt still increments.
- Without the macro: cfg_ip_only is ignored, and every frame is TOTAL words with a full commit.

Decomposition:
- Shared package slp_pkg holds:
  - the default dimension constants;
  - localparams TOTAL and the segment base offsets (IB_BASE=ID, HB_BASE, OB_BASE);
  - the commit-point state value function of HOD/OD;
  - the state enum {FILL, PEND}.
- Sub-module slp_seg_decode: combinational idx → {seg, offset}, reused by the engine-side debug logic.

Test Plan:
- Reset, then stream 60 words 1..60 with s_last on word 60, then pulse the commit point → act_ip MSB word=1, act_ip LSB word=10, act_ib MSB word=11, act_ob LSB word=60, act_valid=1, frame_cnt=1.
- Frame 1 committed; stream frame 2 (words 101..160) with no commit point for 200 cycles → act_* still hold frame 1 and s_ready=0 after word 160. Then assert the commit point → frame 2 visible, frame_cnt=2.
- s_last on word 30 → err_len=1, idx=0, act_* unchanged. A following correct 60-word frame commits normally; err_len stays 1.
- s_valid toggled every other cycle → all 60 words captured in order; fill_seg sequence 0,1,2,3 with transitions after words 10, 40, 55.
- Assert rst after word 25 → all outputs zero. A fresh 60-word frame then commits correctly.
- With SLP_LOADER_WEIGHT_SKIP_EN: full frame committed, then a cfg_ip_only frame of 10 words 900..909 → act_ip updated, act_ib/hb/ob unchanged, frame_cnt=2.

Source files
------------

// File: rtl/slp_pkg.sv
// Shared constants, segment-boundary helpers and enums for the perceptron parameter loader.
package slp_pkg;

   localparam int D_ID    = 10;
   localparam int D_HID   = 3;
   localparam int D_HOD   = 5;
   localparam int D_OD    = 1;
   localparam int D_CNT_W = 16;

   // Cumulative word offset at which segment `seg` starts; seg=4 yields the frame length.
   function automatic int seg_base(input int seg, input int id, input int hid,
                                   input int hod, input int od);
      int b = 0;
      if (seg > 0) b += id;
      if (seg > 1) b += id * hid;
      if (seg > 2) b += hid * hod;
      if (seg > 3) b += hod * od;
      return b;
   endfunction

   localparam int IB_BASE = seg_base(1, D_ID, D_HID, D_HOD, D_OD);
   localparam int HB_BASE = seg_base(2, D_ID, D_HID, D_HOD, D_OD);
   localparam int OB_BASE = seg_base(3, D_ID, D_HID, D_HOD, D_OD);
   localparam int TOTAL   = seg_base(4, D_ID, D_HID, D_HOD, D_OD);

   // Engine state of the last output-layer cycle, just before it wraps to 0 and samples.
   function automatic logic [7:0] commit_state(input int hod, input int od);
      return 8'((hod + 2) * od + 2);
   endfunction

   typedef enum logic {FILL, PEND} state_t;
   typedef enum logic [1:0] {SEG_IP, SEG_IB, SEG_HB, SEG_OB} seg_t;

endpackage

// File: rtl/slp_seg_decode.sv
// Combinational split of a global frame word index into {segment, offset within segment}.
module slp_seg_decode
   import slp_pkg::*;
#(
   parameter int ID    = D_ID,
   parameter int HID   = D_HID,
   parameter int HOD   = D_HOD,
   parameter int OD    = D_OD,
   parameter int IDX_W = $clog2(seg_base(4, D_ID, D_HID, D_HOD, D_OD))
) (
   input  logic [IDX_W-1:0] idx,
   output seg_t             seg,
   output logic [IDX_W-1:0] offset
);

   localparam logic [IDX_W-1:0] IB_B = IDX_W'(seg_base(1, ID, HID, HOD, OD));
   localparam logic [IDX_W-1:0] HB_B = IDX_W'(seg_base(2, ID, HID, HOD, OD));
   localparam logic [IDX_W-1:0] OB_B = IDX_W'(seg_base(3, ID, HID, HOD, OD));

   // NOTE: every output gets a default first, so no path through the block infers a latch.
   always_comb begin
      seg    = SEG_IP;
      offset = idx;
      if (idx >= OB_B) begin
         seg    = SEG_OB;
         offset = idx - OB_B;
      end else if (idx >= HB_B) begin
         seg    = SEG_HB;
         offset = idx - HB_B;
      end else if (idx >= IB_B) begin
         seg    = SEG_IB;
         offset = idx - IB_B;
      end
   end

endmodule

// File: rtl/slp_param_loader.sv
// Streams parameter words into a shadow set and commits it at the engine's frame boundary.
// Optional macro SLP_LOADER_WEIGHT_SKIP_EN enables input-vector-only frames (cfg_ip_only).
module slp_param_loader
   import slp_pkg::*;
#(
   parameter int ID    = D_ID,
   parameter int HID   = D_HID,
   parameter int HOD   = D_HOD,
   parameter int OD    = D_OD,
   parameter int CNT_W = D_CNT_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             s_data,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic                    s_last,
   input  logic                    cfg_ip_only,
   input  logic [7:0]              slp_state,
   input  logic [1:0]              slp_level,
   output logic [ID*32-1:0]        act_ip,
   output logic [ID*HID*32-1:0]    act_ib,
   output logic [HID*HOD*32-1:0]   act_hb,
   output logic [HOD*OD*32-1:0]    act_ob,
   output logic                    act_valid,
   output logic [1:0]              fill_seg,
   output logic                    err_len,
   output logic [CNT_W-1:0]        frame_cnt
);

   localparam int               TOT       = seg_base(4, ID, HID, HOD, OD);
   localparam int               IDX_W     = $clog2(TOT);
   localparam logic [IDX_W-1:0] LAST_FULL = IDX_W'(TOT - 1);
   localparam logic [IDX_W-1:0] LAST_IP   = IDX_W'(ID - 1);
   localparam logic [7:0]       COMMIT_ST = commit_state(HOD, OD);

   state_t                  state;
   logic [IDX_W-1:0]        idx;
   seg_t                    seg;
   logic [IDX_W-1:0]        offset;
   logic [ID*32-1:0]        sh_ip;
   logic [ID*HID*32-1:0]    sh_ib;
   logic [HID*HOD*32-1:0]   sh_hb;
   logic [HOD*OD*32-1:0]    sh_ob;
   logic                    xfer;
   logic                    commit;
   logic                    frame_ip_only;
   logic                    held_ip_only;
   logic [IDX_W-1:0]        last_idx;

   slp_seg_decode #(.ID(ID), .HID(HID), .HOD(HOD), .OD(OD), .IDX_W(IDX_W)) u_decode (
      .idx    (idx),
      .seg    (seg),
      .offset (offset)
   );

   assign xfer     = s_valid && s_ready;
   assign commit   = (state == PEND) && (slp_level == 2'd2) && (slp_state == COMMIT_ST);
   assign fill_seg = (state == FILL) ? seg : SEG_IP;
   assign last_idx = frame_ip_only ? LAST_IP : LAST_FULL;

`ifdef SLP_LOADER_WEIGHT_SKIP_EN
   logic ip_only_q;

   // The flag is taken live on the first word and held for the rest of the frame and its commit.
   always_ff @(posedge clk) begin
      if (rst)                     ip_only_q <= 1'b0;
      else if (xfer && idx == '0)  ip_only_q <= cfg_ip_only;
   end

   assign frame_ip_only = (idx == '0) ? cfg_ip_only : ip_only_q;
   assign held_ip_only  = ip_only_q;
`else
   logic unused_cfg;
   assign unused_cfg    = cfg_ip_only;
   assign frame_ip_only = 1'b0;
   assign held_ip_only  = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FILL;
         idx       <= '0;
         s_ready   <= 1'b0;
         err_len   <= 1'b0;
         act_valid <= 1'b0;
         frame_cnt <= '0;
      end else begin
         unique case (state)
            FILL: begin
               s_ready <= 1'b1;
               if (xfer) begin
                  if (idx == last_idx && s_last) begin
                     state   <= PEND;
                     s_ready <= 1'b0;
                     idx     <= '0;
                  end else if (s_last || idx == last_idx) begin
                     err_len <= 1'b1;
                     idx     <= '0;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end
            PEND: begin
               if (commit) begin
                  state     <= FILL;
                  s_ready   <= 1'b1;
                  act_valid <= 1'b1;
                  frame_cnt <= frame_cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

   // NOTE: the shadow is a register bank, not RAM, and is explicitly cleared on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_ip <= '0;
         sh_ib <= '0;
         sh_hb <= '0;
         sh_ob <= '0;
      end else if (xfer) begin
         // Element k of an N-word segment sits at word N-1-k, so the first word is the MSB word.
         case (seg)
            SEG_IP: sh_ip[(ID - 1 - int'(offset)) * 32 +: 32]        <= s_data;
            SEG_IB: sh_ib[(ID * HID - 1 - int'(offset)) * 32 +: 32]  <= s_data;
            SEG_HB: sh_hb[(HID * HOD - 1 - int'(offset)) * 32 +: 32] <= s_data;
            SEG_OB: sh_ob[(HOD * OD - 1 - int'(offset)) * 32 +: 32]  <= s_data;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         act_ip <= '0;
         act_ib <= '0;
         act_hb <= '0;
         act_ob <= '0;
      end else if (commit) begin
         act_ip <= sh_ip;
         if (!held_ip_only) begin
            act_ib <= sh_ib;
            act_hb <= sh_hb;
            act_ob <= sh_ob;
         end
      end
   end

endmodule
